// File: rtl/duckhunt_pkg.sv
// Shared types for the Duck Hunt round sequencer: FSM state enum, display codes, saturating add.
package duckhunt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SPAWN     = 4'd1,
        ST_FLY       = 4'd2,
        ST_ESCAPE    = 4'd3,
        ST_FALL      = 4'd4,
        ST_NEXT      = 4'd5,
        ST_ROUND_END = 4'd6,
        ST_DONE      = 4'd7
    } state_t;

    // Display codes consumed by the sprite mux; FLY, ESCAPE and NEXT share one code.
    localparam logic [2:0] DISP_IDLE      = 3'b000;
    localparam logic [2:0] DISP_SPAWN     = 3'b001;
    localparam logic [2:0] DISP_FLY       = 3'b010;
    localparam logic [2:0] DISP_DONE      = 3'b011;
    localparam logic [2:0] DISP_FALL      = 3'b100;
    localparam logic [2:0] DISP_ROUND_END = 3'b101;

    // a + b clamped to the all-ones value of a w-bit field (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (33'd1 << w) - 33'd1;
        return (sum > max) ? max[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/shot_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
// Latency: count updates on the edge after clr/load/dec. No backpressure.
// Priority: clr > load > dec.
module shot_counter
    import duckhunt_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/round_control.sv
// Duck Hunt game sequencer: rounds of ducks, shot/hit/round/score counters, game-over detection.
// Latency: Moore outputs, start -> new_duck in 1 cycle. No backpressure; inputs are level/pulse flags.
// Optional PERFECT_BONUS_EN adds BONUS to the score on a perfect round and exposes bonus_pulse.
module round_control
    import duckhunt_pkg::*;
#(
    parameter int DUCKS_PER_ROUND = 2,
    parameter int SHOTS_PER_DUCK  = 3,
    parameter int ROUNDS_MAX      = 10,
    parameter int PASS_HITS       = 1,
    parameter int SCORE_W         = 12,
    parameter int BONUS           = 10
) (
    input  logic                                   Clk,
    input  logic                                   Reset,
    input  logic                                   start,
    input  logic                                   trigger,
    input  logic                                   bird_shot,
    input  logic                                   flew_away,
    input  logic                                   duck_ded_done,
    output logic [2:0]                             state,
    output logic                                   new_duck,
    output logic                                   round_start,
    output logic [$clog2(SHOTS_PER_DUCK+1)-1:0]    shots_left,
    output logic [$clog2(DUCKS_PER_ROUND)+1-1:0]   duck_idx,
    output logic [$clog2(DUCKS_PER_ROUND+1)-1:0]   round_hits,
    output logic [$clog2(ROUNDS_MAX+1)-1:0]        round_num,
    output logic [SCORE_W-1:0]                     total_score,
    output logic                                   game_over,
`ifdef PERFECT_BONUS_EN
    output logic                                   bonus_pulse,
`endif
    output logic                                   game_won
);

    localparam int SHOT_W = $clog2(SHOTS_PER_DUCK+1);
    localparam int HIT_W  = $clog2(DUCKS_PER_ROUND+1);
    localparam int RND_W  = $clog2(ROUNDS_MAX+1);
    localparam int DUCK_W = $clog2(DUCKS_PER_ROUND)+1;

    if (PASS_HITS > DUCKS_PER_ROUND || BONUS < 0 || SCORE_W > 32) begin : g_bad_cfg
        $error("round_control: invalid parameter combination");
    end

    state_t st, st_nxt;
    logic   shots_zero;
    logic   last_duck, last_round, round_pass;

    assign last_duck  = (int'(duck_idx) == DUCKS_PER_ROUND-1);
    assign last_round = (int'(round_num) == ROUNDS_MAX);
    assign round_pass = (int'(round_hits) >= PASS_HITS);

    shot_counter #(.W(SHOT_W)) u_shots (
        .Clk      (Clk),
        .Reset    (Reset),
        .clr      (st == ST_IDLE),
        .load     (st == ST_SPAWN),
        .load_val (SHOT_W'(SHOTS_PER_DUCK)),
        .dec      ((st == ST_FLY) && trigger),
        .count    (shots_left),
        .zero     (shots_zero)
    );

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:      if (start) st_nxt = ST_SPAWN;
            ST_SPAWN:     st_nxt = ST_FLY;
            ST_FLY: begin
                if (bird_shot)       st_nxt = ST_FALL;
                else if (flew_away)  st_nxt = ST_NEXT;
                else if (shots_zero) st_nxt = ST_ESCAPE;
            end
            ST_ESCAPE:    if (flew_away) st_nxt = ST_NEXT;
            ST_FALL:      if (duck_ded_done) st_nxt = ST_NEXT;
            ST_NEXT:      st_nxt = last_duck ? ST_ROUND_END : ST_SPAWN;
            ST_ROUND_END: st_nxt = (!round_pass || last_round) ? ST_DONE : ST_SPAWN;
            ST_DONE:      if (start) st_nxt = ST_IDLE;
            default:      st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            st          <= ST_IDLE;
            duck_idx    <= '0;
            round_hits  <= '0;
            round_num   <= '0;
            total_score <= '0;
            game_won    <= 1'b0;
        end else begin
            st <= st_nxt;
            case (st)
                ST_IDLE: begin
                    duck_idx    <= '0;
                    round_hits  <= '0;
                    total_score <= '0;
                    game_won    <= 1'b0;
                    round_num   <= start ? RND_W'(1) : '0;
                end
                ST_FLY: begin
                    if (bird_shot) begin
                        round_hits  <= round_hits + HIT_W'(1);
                        total_score <= SCORE_W'(sat_add(32'(total_score), 32'd1, SCORE_W));
                    end
                end
                ST_NEXT: begin
                    if (!last_duck) duck_idx <= duck_idx + DUCK_W'(1);
                end
                ST_ROUND_END: begin
`ifdef PERFECT_BONUS_EN
                    if (int'(round_hits) == DUCKS_PER_ROUND)
                        total_score <= SCORE_W'(sat_add(32'(total_score), 32'(BONUS), SCORE_W));
`endif
                    if (!round_pass) begin
                        game_won <= 1'b0;
                    end else if (last_round) begin
                        game_won <= 1'b1;
                    end else begin
                        round_num  <= round_num + RND_W'(1);
                        duck_idx   <= '0;
                        round_hits <= '0;
                    end
                end
                ST_DONE: begin
                    if (start) game_won <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state = DISP_IDLE;
        case (st)
            ST_SPAWN:                    state = DISP_SPAWN;
            ST_FLY, ST_ESCAPE, ST_NEXT:  state = DISP_FLY;
            ST_FALL:                     state = DISP_FALL;
            ST_ROUND_END:                state = DISP_ROUND_END;
            ST_DONE:                     state = DISP_DONE;
            default:                     state = DISP_IDLE;
        endcase
    end

    assign new_duck    = (st == ST_SPAWN);
    assign round_start = (st == ST_SPAWN) && (duck_idx == '0);
    assign game_over   = (st == ST_DONE);
`ifdef PERFECT_BONUS_EN
    assign bonus_pulse = (st == ST_ROUND_END) && (int'(round_hits) == DUCKS_PER_ROUND);
`endif

endmodule

// File: tb/tb_round_control.sv
// Self-checking bench for round_control: directed scenarios plus randomized games vs a game-level model.
module tb_round_control;

    localparam int D   = 2;
    localparam int S   = 3;
    localparam int R   = 2;
    localparam int P   = 1;
    localparam int SW  = 12;
    localparam int BON = 10;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          start = 1'b0, trigger = 1'b0, bird_shot = 1'b0, flew_away = 1'b0, duck_ded_done = 1'b0;
    logic [2:0]    state;
    logic          new_duck, round_start, game_over, game_won;
    logic [1:0]    shots_left, duck_idx, round_hits, round_num;
    logic [SW-1:0] total_score;
`ifdef PERFECT_BONUS_EN
    logic          bonus_pulse;
    localparam int BONUS_ADD = BON;
`else
    localparam int BONUS_ADD = 0;
`endif

    int errors = 0;
    int checks = 0;

    round_control #(
        .DUCKS_PER_ROUND(D), .SHOTS_PER_DUCK(S), .ROUNDS_MAX(R),
        .PASS_HITS(P), .SCORE_W(SW), .BONUS(BON)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .trigger(trigger), .bird_shot(bird_shot),
        .flew_away(flew_away), .duck_ded_done(duck_ded_done), .state(state), .new_duck(new_duck),
        .round_start(round_start), .shots_left(shots_left), .duck_idx(duck_idx),
        .round_hits(round_hits), .round_num(round_num), .total_score(total_score),
        .game_over(game_over),
`ifdef PERFECT_BONUS_EN
        .bonus_pulse(bonus_pulse),
`endif
        .game_won(game_won)
    );

    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse(input bit t, input bit b, input bit f, input bit d, input bit s);
        trigger = t; bird_shot = b; flew_away = f; duck_ded_done = d; start = s;
        tick();
        trigger = 0; bird_shot = 0; flew_away = 0; duck_ded_done = 0; start = 0;
    endtask

    task automatic do_reset();
        Reset = 1; tick(); Reset = 0;
    endtask

    task automatic test_reset();
        Reset = 1; start = 1;
        tick(); tick();
        start = 0;
        checks++;
        if (state !== 3'b000 || round_num !== 0 || total_score !== 0 || shots_left !== 0 ||
            duck_idx !== 0 || round_hits !== 0 || new_duck !== 0 || game_over !== 0 || game_won !== 0) begin
            errors++;
            $display("FAIL reset: state=%0d round=%0d score=%0d shots=%0d duck=%0d hits=%0d nd=%0d go=%0d gw=%0d, want all 0",
                     state, round_num, total_score, shots_left, duck_idx, round_hits, new_duck, game_over, game_won);
        end
        Reset = 0;
    endtask

    task automatic test_full_round();
        int nd;
        do_reset();
        pulse(0, 0, 0, 0, 1);
        nd = new_duck;
        checks++;
        if (state !== 3'b001 || new_duck !== 1 || round_start !== 1 || round_num !== 1) begin
            errors++;
            $display("FAIL first_spawn: state=%0d nd=%0d rs=%0d round=%0d, want 1 1 1 1", state, new_duck, round_start, round_num);
        end
        pulse(0, 0, 0, 0, 0);
        nd += new_duck;
        checks++;
        if (state !== 3'b010 || shots_left !== 2'(S)) begin
            errors++;
            $display("FAIL first_fly: state=%0d shots=%0d, want 2 %0d", state, shots_left, S);
        end
        for (int k = 0; k < D; k++) begin
            if (k > 0) begin
                pulse(0, 0, 0, 0, 0);
                nd += new_duck;
                checks++;
                if (state !== 3'b001 || duck_idx !== 2'(k) || round_start !== 0) begin
                    errors++;
                    $display("FAIL spawn_duck%0d: state=%0d duck=%0d rs=%0d, want 1 %0d 0", k, state, duck_idx, round_start, k);
                end
                pulse(0, 0, 0, 0, 0);
                nd += new_duck;
            end
            pulse(0, 1, 0, 0, 0);
            checks++;
            if (state !== 3'b100 || round_hits !== 2'(k+1) || total_score !== SW'(k+1)) begin
                errors++;
                $display("FAIL hit_duck%0d: state=%0d hits=%0d score=%0d, want 4 %0d %0d", k, state, round_hits, total_score, k+1, k+1);
            end
            pulse(0, 0, 0, 0, 0);
            pulse(0, 0, 0, 1, 0);
        end
        pulse(0, 0, 0, 0, 0);
        checks++;
        if (state !== 3'b101 || round_hits !== 2'(D)) begin
            errors++;
            $display("FAIL round_end: state=%0d hits=%0d, want 5 %0d", state, round_hits, D);
        end
`ifdef PERFECT_BONUS_EN
        checks++;
        if (bonus_pulse !== 1) begin
            errors++;
            $display("FAIL bonus_pulse_high: got %0d want 1", bonus_pulse);
        end
`endif
        pulse(0, 0, 0, 0, 0);
        nd += new_duck;
        checks++;
        if (state !== 3'b001 || round_num !== 2 || duck_idx !== 0 || round_hits !== 0 ||
            total_score !== SW'(D + BONUS_ADD) || round_start !== 1 || nd !== D + 1) begin
            errors++;
            $display("FAIL round2_spawn: state=%0d round=%0d duck=%0d hits=%0d score=%0d rs=%0d new_duck_pulses=%0d, want 1 2 0 0 %0d 1 %0d",
                     state, round_num, duck_idx, round_hits, total_score, round_start, nd, D + BONUS_ADD, D + 1);
        end
`ifdef PERFECT_BONUS_EN
        checks++;
        if (bonus_pulse !== 0) begin
            errors++;
            $display("FAIL bonus_pulse_low: got %0d want 0", bonus_pulse);
        end
`endif
    endtask

    task automatic test_escape_and_zero_round();
        do_reset();
        pulse(0, 0, 0, 0, 1);
        pulse(0, 0, 0, 0, 0);
        for (int k = 1; k <= S; k++) begin
            pulse(1, 0, 0, 0, 0);
            checks++;
            if (shots_left !== 2'(S - k) || state !== 3'b010) begin
                errors++;
                $display("FAIL trigger%0d: shots=%0d state=%0d, want %0d 2", k, shots_left, state, S - k);
            end
        end
        pulse(1, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        checks++;
        if (shots_left !== 0 || state !== 3'b010 || round_hits !== 0 || total_score !== 0) begin
            errors++;
            $display("FAIL escape_ignores: shots=%0d state=%0d hits=%0d score=%0d, want 0 2 0 0", shots_left, state, round_hits, total_score);
        end
        pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 0, 0, 0);
        checks++;
        if (state !== 3'b001 || duck_idx !== 1) begin
            errors++;
            $display("FAIL escape_next_spawn: state=%0d duck=%0d, want 1 1", state, duck_idx);
        end
        pulse(0, 0, 0, 0, 0);
        pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 0, 0, 0);
        checks++;
        if (state !== 3'b101) begin
            errors++;
            $display("FAIL zero_round_end: state=%0d, want 5", state);
        end
        pulse(0, 0, 0, 0, 0);
        checks++;
        if (state !== 3'b011 || game_over !== 1 || game_won !== 0 || round_num !== 1) begin
            errors++;
            $display("FAIL zero_round_done: state=%0d go=%0d gw=%0d round=%0d, want 3 1 0 1", state, game_over, game_won, round_num);
        end
        pulse(0, 0, 0, 0, 0);
        checks++;
        if (state !== 3'b011 || round_num !== 1) begin
            errors++;
            $display("FAIL done_hold: state=%0d round=%0d, want 3 1", state, round_num);
        end
    endtask

    task automatic test_same_cycle_and_reset_fall();
        do_reset();
        pulse(0, 0, 0, 0, 1);
        pulse(0, 0, 0, 0, 0);
        pulse(1, 1, 1, 0, 0);
        checks++;
        if (state !== 3'b100 || shots_left !== 2'(S - 1) || round_hits !== 1 || total_score !== 1) begin
            errors++;
            $display("FAIL same_cycle: state=%0d shots=%0d hits=%0d score=%0d, want 4 %0d 1 1", state, shots_left, round_hits, total_score, S - 1);
        end
        Reset = 1; duck_ded_done = 1; start = 1;
        tick();
        Reset = 0; duck_ded_done = 0; start = 0;
        checks++;
        if (state !== 3'b000 || shots_left !== 0 || round_hits !== 0 || total_score !== 0 ||
            round_num !== 0 || duck_idx !== 0 || new_duck !== 0 || game_over !== 0 || game_won !== 0) begin
            errors++;
            $display("FAIL reset_mid_fall: state=%0d shots=%0d hits=%0d score=%0d round=%0d duck=%0d, want all 0",
                     state, shots_left, round_hits, total_score, round_num, duck_idx);
        end
    endtask

    // Game-level model: per duck, outcome and trigger count are random; expectations follow the game rules.
    task automatic play_game(input bit all_hits);
        int e_round, e_hits, e_duck, e_score, e_shots, n, t, guard;
        bit hit, done, won;
        e_round = 1; e_hits = 0; e_duck = 0; e_score = 0; done = 0; won = 0; guard = 0;
        do_reset();
        pulse(0, 0, 0, 0, 1);
        while (!done && guard < 60) begin
            guard++;
            checks++;
            if (state !== 3'b001 || new_duck !== 1 || duck_idx !== 2'(e_duck) || round_num !== 2'(e_round) ||
                round_start !== (e_duck == 0)) begin
                errors++;
                $display("FAIL game_spawn: state=%0d nd=%0d duck=%0d round=%0d rs=%0d, want 1 1 %0d %0d %0d",
                         state, new_duck, duck_idx, round_num, round_start, e_duck, e_round, e_duck == 0);
            end
            pulse(0, 0, 0, 0, 0);
            hit = all_hits || ($urandom_range(0, 1) == 1);
            if (hit) begin
                n = $urandom_range(0, S - 1);
                t = $urandom_range(0, 1);
                repeat (n) pulse(1, 0, 0, 0, 0);
                pulse(t[0], 1, $urandom_range(0, 1) == 1, 0, 0);
                e_shots = S - n - t;
                e_hits++;
                e_score++;
                repeat ($urandom_range(0, 3)) pulse($urandom_range(0, 1) == 1, 1, $urandom_range(0, 1) == 1, 0, 0);
                checks++;
                if (state !== 3'b100 || shots_left !== 2'(e_shots) || round_hits !== 2'(e_hits) || total_score !== SW'(e_score)) begin
                    errors++;
                    $display("FAIL game_fall: state=%0d shots=%0d hits=%0d score=%0d, want 4 %0d %0d %0d",
                             state, shots_left, round_hits, total_score, e_shots, e_hits, e_score);
                end
                pulse(0, 0, 0, 1, 0);
            end else begin
                n = $urandom_range(0, S + 1);
                repeat (n) pulse(1, 0, 0, 0, 0);
                e_shots = (n > S) ? 0 : S - n;
                checks++;
                if (state !== 3'b010 || shots_left !== 2'(e_shots) || round_hits !== 2'(e_hits)) begin
                    errors++;
                    $display("FAIL game_miss: state=%0d shots=%0d hits=%0d, want 2 %0d %0d", state, shots_left, round_hits, e_shots, e_hits);
                end
                pulse(0, 0, 1, 0, 0);
            end
            pulse(0, 0, 0, 0, 0);
            if (e_duck == D - 1) begin
                checks++;
                if (state !== 3'b101 || round_hits !== 2'(e_hits)) begin
                    errors++;
                    $display("FAIL game_round_end: state=%0d hits=%0d, want 5 %0d", state, round_hits, e_hits);
                end
`ifdef PERFECT_BONUS_EN
                checks++;
                if (bonus_pulse !== (e_hits == D)) begin
                    errors++;
                    $display("FAIL game_bonus_pulse: got %0d want %0d", bonus_pulse, e_hits == D);
                end
`endif
                if (e_hits == D) e_score += BONUS_ADD;
                pulse(0, 0, 0, 0, 0);
                if (e_hits < P) begin
                    done = 1; won = 0;
                end else if (e_round == R) begin
                    done = 1; won = 1;
                end else begin
                    e_round++; e_hits = 0; e_duck = 0;
                end
            end else begin
                e_duck++;
            end
        end
        checks++;
        if (state !== 3'b011 || game_over !== 1 || game_won !== won || round_num !== 2'(e_round) || total_score !== SW'(e_score)) begin
            errors++;
            $display("FAIL game_done: state=%0d go=%0d gw=%0d round=%0d score=%0d, want 3 1 %0d %0d %0d",
                     state, game_over, game_won, round_num, total_score, won, e_round, e_score);
        end
        pulse(0, 0, 0, 0, 1);
        checks++;
        if (state !== 3'b000 || game_won !== 0 || game_over !== 0) begin
            errors++;
            $display("FAIL game_leave_done: state=%0d gw=%0d go=%0d, want 0 0 0", state, game_won, game_over);
        end
        pulse(0, 0, 0, 0, 0);
        checks++;
        if (round_num !== 0 || total_score !== 0 || duck_idx !== 0 || round_hits !== 0 || shots_left !== 0) begin
            errors++;
            $display("FAIL game_idle_clear: round=%0d score=%0d duck=%0d hits=%0d shots=%0d, want all 0",
                     round_num, total_score, duck_idx, round_hits, shots_left);
        end
    endtask

    task automatic test_win();
        play_game(1);
    endtask

    task automatic test_random_games();
        for (int g = 0; g < 8; g++) play_game(0);
    endtask

    initial begin
        test_reset();
        test_full_round();
        test_escape_and_zero_round();
        test_same_cycle_and_reset_fall();
        test_win();
        test_random_games();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_control.md
Name: round_control

Overview:
- Parametrised successor to the single-duck game FSM: sequences a full Duck Hunt game of ROUNDS_MAX rounds, each with DUCKS_PER_ROUND ducks.
- Owns the shot, hit, round and score counters internally, and derives game-over itself instead of taking it as an input.
- Sits between the input/sprite logic (trigger, hit detection, fly-away and fall-animation flags) and the display/score logic.
- Keeps the 3-bit state code so the existing sprite muxing is unchanged.

Parameters:
- DUCKS_PER_ROUND, 2, ducks spawned per round (>=1).
- SHOTS_PER_DUCK, 3, shots available per duck (>=1).
- ROUNDS_MAX, 10, final round number (>=1).
- PASS_HITS, 1, minimum hits in a round to advance (0..DUCKS_PER_ROUND).
- SCORE_W, 12, width of total_score.
- BONUS, 10, perfect-round bonus; used only with the optional feature.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high; forces IDLE and clears all counters
- start  in  1  level; begins a game from IDLE, returns to IDLE from DONE
- trigger  in  1  single-cycle pulse per shot fired
- bird_shot  in  1  hit detected on the current duck
- flew_away  in  1  current duck has left the screen
- duck_ded_done  in  1  fall animation finished
- state  out  3  display code: IDLE 000, SPAWN 001, FLY/ESCAPE/NEXT 010, DONE 011, FALL 100, ROUND_END 101
- new_duck  out  1  high for exactly the one SPAWN cycle
- round_start  out  1  high in SPAWN when duck_idx==0
- shots_left  out  $clog2(SHOTS_PER_DUCK+1)  shots remaining for the current duck
- duck_idx  out  $clog2(DUCKS_PER_ROUND)+1  index of the current duck within the round, 0-based
- round_hits  out  $clog2(DUCKS_PER_ROUND+1)  hits in the current round
- round_num  out  $clog2(ROUNDS_MAX+1)  current round, 1-based; 0 in IDLE
- total_score  out  SCORE_W  cumulative hits (plus bonuses); saturates at all-ones
- game_over  out  1  high only in DONE
- game_won  out  1  registered; set when DONE is entered after passing round ROUNDS_MAX, cleared on leaving DONE

Behaviour:
- Moore FSM: registered state plus registered counters. Outputs decode from the current state and counters; none depend combinationally on inputs.
- Reset: state IDLE, all counters 0, all flags 0. A Reset asserted in any state wins over every other event in that cycle.
- IDLE:
  - counters held at 0
  - start -> SPAWN, loading round_num=1, duck_idx=0, round_hits=0, total_score=0
- SPAWN: one cycle; shots_left<=SHOTS_PER_DUCK; -> FLY.
- FLY:
  - trigger with shots_left>0 decrements shots_left; a trigger at 0 is ignored (no underflow).
  - Transition priority: bird_shot -> FALL with round_hits+1 and total_score+1 in the same edge; else flew_away -> NEXT; else shots_left==0 -> ESCAPE.
  - A trigger and bird_shot in the same cycle both take effect.
- ESCAPE: triggers ignored, bird_shot ignored; flew_away -> NEXT.
- FALL: all inputs ignored except duck_ded_done -> NEXT.
- NEXT: one cycle.
  - if duck_idx==DUCKS_PER_ROUND-1 -> ROUND_END
  - else duck_idx+1 and -> SPAWN
- ROUND_END: one cycle.
  - round_hits<PASS_HITS -> DONE with game_won=0
  - else round_num==ROUNDS_MAX -> DONE with game_won=1
  - else round_num+1, duck_idx=0, round_hits=0, -> SPAWN
- DONE:
  - counters frozen for score display
  - start -> IDLE, which clears the counters on the following edges
- Illegal state encodings recover to IDLE on the next edge.
- Latency: start to first new_duck is 1 cycle. Hit to next SPAWN is duck_ded_done+2 cycles, or +3 at a round boundary.

Optional Feature:
- Macro PERFECT_BONUS_EN.
- Defined: on the ROUND_END edge, if round_hits==DUCKS_PER_ROUND, total_score += BONUS (saturating). A bonus_pulse output (1 bit) is present and is high during that ROUND_END cycle.
- Undefined: no bonus is added, the bonus_pulse port does not exist, and the BONUS parameter is unused.

Decomposition:
- Package duckhunt_pkg holds:
  - the state enum (4-bit) and the 3-bit display-code localparams
  - a saturating-add function used for total_score
- One sub-module, shot_counter: loadable down-counter with a zero flag, used for shots_left.
- All other counters stay inline.

Test Plan:
- Defaults; start, then bird_shot in FLY for both ducks, duck_ded_done each time -> round_hits=2, total_score=2, round_num becomes 2, new_duck pulses once per SPAWN.
- Fire 3 triggers with no hit -> shots_left 3,2,1,0, state ESCAPE; a 4th trigger keeps shots_left=0; flew_away -> NEXT.
- Round with 0 hits (PASS_HITS=1): both ducks fly away -> ROUND_END then DONE, game_over=1, game_won=0, round_num still 1.
- ROUNDS_MAX=2, all hits -> DONE after round 2 with game_won=1, total_score=4; start -> IDLE and counters 0.
- Same-cycle trigger+bird_shot+flew_away in FLY -> FALL, shots_left decremented, round_hits+1.
- Reset mid-FALL -> next cycle state=000 with all outputs 0. With PERFECT_BONUS_EN, a perfect round gives total_score=2+BONUS=12 and bonus_pulse for 1 cycle.
